serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
- Sequential restoring divider. It is the inverse of the team's shift-add serial multiplier: it takes the 8-bit product back to factors.
- Computes QUOTIENT = DIVIDEND / DIVISOR and REMAINDER = DIVIDEND % DIVISOR, producing one quotient bit per clock.
- START/BUSY/DONE handshake so a controller can chain it after the multiplier, e.g. for product-check loops.

Parameters:
- N_W, 8, dividend and quotient width.
- D_W, 4, divisor and remainder width.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset. Low clears all state immediately.
- START  input  1  request. Sampled only in IDLE.
- DIVIDEND  input  N_W  numerator, captured on the accepting edge.
- DIVISOR  input  D_W  denominator, captured on the accepting edge.
- QUOTIENT  output  N_W  result, registered.
- REMAINDER  output  D_W  result, registered.
- BUSY  output  1  high in CALC.
- DONE  output  1  one-cycle pulse, results valid.
- DIV_ZERO  output  1  registered with results. High when the captured divisor was 0.

Behaviour:
- Reset (RESET=0, async): state=IDLE, QUOTIENT=0, REMAINDER=0, BUSY=0, DONE=0, DIV_ZERO=0, internal registers 0.
  - Reset mid-operation aborts the division with no partial result; outputs go to 0.
- States: IDLE, CALC, FINISH.
- IDLE:
  - START=1 at edge k: capture DIVIDEND and DIVISOR, clear the partial remainder (D_W+1 bits) and the bit counter.
  - If the captured DIVISOR!=0, go to CALC.
  - If the captured DIVISOR==0, go straight to FINISH and load QUOTIENT={N_W{1}}, REMAINDER=0, DIV_ZERO=1.
- CALC, one step per edge, processing the dividend MSB first:
  - shifted = {rem[D_W-1:0], next dividend bit}.
  - If shifted >= divisor: rem = shifted - divisor, quotient bit = 1.
  - Otherwise: rem = shifted, quotient bit = 0.
  - Counter runs 0..N_W-1. On step N_W-1, load QUOTIENT/REMAINDER from the final values, DIV_ZERO=0, and go to FINISH.
- FINISH: DONE=1 for exactly one cycle, then IDLE.
- Latency:
  - START accepted at edge k means steps run at edges k+1..k+N_W.
  - DONE is high in the cycle following edge k+N_W (9 clocks after acceptance with defaults).
  - Divide-by-zero: DONE high in the cycle following edge k+1.
- Output hold: QUOTIENT, REMAINDER and DIV_ZERO hold their values until the next completion. They do not clear on START.
- START outside IDLE (CALC or FINISH) is ignored: no queueing, no effect on the running operation.
- START held high continuously starts a new operation on the first IDLE edge after DONE. Operands are re-captured at that edge.
- Operand inputs may change freely after the accepting edge.
- Width rules:
  - Partial remainder is D_W+1 bits so the compare cannot overflow.
  - Final remainder < divisor, so it always fits D_W.
  - Quotient up to 2^N_W-1 (divisor=1).

Decomposition:
- Package serial_div_pkg: state encoding constants (IDLE, CALC, FINISH), default N_W/D_W, and a counter width of clog2(N_W).
- One combinational sub-module is natural: serial_divider_step.
  - Inputs: rem, dividend bit, divisor.
  - Outputs: next rem, quotient bit.
  - Reusable for a future unrolled or pipelined divider.
- The FSM and registers live in serial_divider.

Test Plan:
1. DIVIDEND=99, DIVISOR=11 (inverse of 9x11), START pulse -> BUSY high 8 cycles; DONE pulse 9 cycles after accept; QUOTIENT=9, REMAINDER=0, DIV_ZERO=0.
2. 100/7 -> QUOTIENT=14, REMAINDER=2; 255/1 -> QUOTIENT=255, REMAINDER=0; 0/15 -> QUOTIENT=0, REMAINDER=0; 15/15 -> QUOTIENT=1, REMAINDER=0.
3. DIVIDEND=5, DIVISOR=0 -> DONE in the cycle after the edge following acceptance; QUOTIENT=255, REMAINDER=0, DIV_ZERO=1; BUSY never high.
4. Accept 200/3. During CALC pulse START with 50/5 and change the operand inputs -> result still QUOTIENT=66, REMAINDER=2; no second DONE without a new IDLE START.
5. START held high with 99/9 -> back-to-back results QUOTIENT=11, REMAINDER=0; DONE every 10 cycles; outputs hold between DONEs.
6. Accept 120/7, assert RESET=0 asynchronously mid-CALC (between clock edges) -> all outputs 0 immediately, state IDLE. Release RESET, START 120/7 -> QUOTIENT=17, REMAINDER=1.

Source files
------------

// File: rtl/serial_div_pkg.sv
// Shared definitions for the serial restoring divider.
//   - state_t     : FSM state encoding used by serial_divider
//   - N_W_DEF     : default dividend/quotient width
//   - D_W_DEF     : default divisor/remainder width
//   - cnt_width() : bit-counter width for a given dividend width
package serial_div_pkg;

    localparam int N_W_DEF = 8;
    localparam int D_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Counter has to reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(N_W_DEF);

endpackage

// File: rtl/serial_divider_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_in       in  D_W+1  partial remainder before this step
//   dividend_bit in  1      next dividend bit (MSB first)
//   divisor      in  D_W    divisor
//   rem_out      out D_W+1  partial remainder after this step
//   quot_bit     out 1      quotient bit produced by this step
module serial_divider_step
    import serial_div_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic [D_W:0]   rem_in,
    input  logic           dividend_bit,
    input  logic [D_W-1:0] divisor,
    output logic [D_W:0]   rem_out,
    output logic           quot_bit
);

    logic [D_W:0] shifted;
    logic [D_W:0] divisor_ext;
    logic         ge;

    always_comb begin
        shifted     = {rem_in[D_W-1:0], dividend_bit};
        divisor_ext = {1'b0, divisor};
        // A set MSB on the incoming remainder would mean the shifted value
        // exceeds any divisor; with rem_in < divisor it is always 0.
        ge          = rem_in[D_W] | (shifted >= divisor_ext);
        if (ge) begin
            rem_out  = shifted - divisor_ext;
            quot_bit = 1'b1;
        end else begin
            rem_out  = shifted;
            quot_bit = 1'b0;
        end
    end

endmodule

// File: rtl/serial_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Ports:
//   clk        in  1    rising-edge clock
//   reset      in  1    asynchronous active-low reset
//   start      in  1    request, sampled only in IDLE
//   dividend   in  N_W  numerator, captured on the accepting edge
//   divisor    in  D_W  denominator, captured on the accepting edge
//   quotient   out N_W  registered result
//   remainder  out D_W  registered result
//   busy       out 1    high while stepping (CALC)
//   done       out 1    one-cycle pulse, results valid
//   div_zero   out 1    captured divisor was zero (registered with results)
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one restoring step per edge
// FINISH | pulse done, then back to IDLE
module serial_divider
    import serial_div_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           busy,
    output logic           done,
    output logic           div_zero
);

    localparam int                CNT_W    = cnt_width(N_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_W - 1);

    state_t           state_q,     state_d;
    logic [N_W-1:0]   dividend_q,  dividend_d;
    logic [D_W-1:0]   divisor_q,   divisor_d;
    logic [D_W:0]     rem_q,       rem_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [N_W-1:0]   quotient_q,  quotient_d;
    logic [D_W-1:0]   remainder_q, remainder_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             div_zero_q,  div_zero_d;

    logic [D_W:0]     rem_next;
    logic             quot_bit;

    serial_divider_step #(
        .D_W (D_W)
    ) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dividend_q[N_W-1]),
        .divisor      (divisor_q),
        .rem_out      (rem_next),
        .quot_bit     (quot_bit)
    );

    // The dividend register doubles as the quotient accumulator: each step
    // shifts out the consumed dividend bit and shifts in the new quotient bit.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    rem_d      = '0;
                    cnt_d      = '0;
                    if (divisor == '0) begin
                        state_d     = ST_FINISH;
                        quotient_d  = '1;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_CALC: begin
                dividend_d = {dividend_q[N_W-2:0], quot_bit};
                rem_d      = rem_next;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    quotient_d  = {dividend_q[N_W-2:0], quot_bit};
                    // Final remainder is below the divisor, so the top bit is 0.
                    remainder_d = rem_next[D_W-1:0];
                    div_zero_d  = 1'b0;
                    state_d     = ST_FINISH;
                    done_d      = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end

            ST_FINISH: begin
                // Arriving from CALC, done is already up: drop it and leave.
                // Arriving from a zero divisor, done is raised here first.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider against an arithmetic reference.
module tb_serial_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    int errors = 0;
    int checks = 0;
    logic [7:0] last_q = 8'd0;

    always #5 clk = ~clk;

    serial_divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic dz);
        if (b == 4'd0) begin
            q = 8'hFF; r = 4'd0; dz = 1'b1;
        end else begin
            q = a / b; r = 4'(a % b); dz = 1'b0;
        end
    endfunction

    // Start one division and follow it to DONE. With disturb set, the
    // operand inputs churn during CALC and START is pulsed mid-operation.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input bit disturb, input string tag);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        int         n;
        int         bc;
        model(a, b, eq, er, ez);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        n  = 1;
        bc = 0;
        if (!ez) chk({tag, "_hold_on_start"}, quotient, last_q);
        while (!done && n < 40) begin
            bc += int'(busy);
            if (disturb) begin
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
                start    = (n == 3);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, ez ? 2 : 9);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_div_zero"}, div_zero, ez);
        chk({tag, "_busy_cycles"}, bc, ez ? 0 : 8);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_quotient_held"}, quotient, eq);
        last_q = eq;
    endtask

    initial begin
        int ndone;
        int bad_hold;
        int t_done[3];
        int cyc;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        #12;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_div_zero", div_zero, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(8'd99,  4'd11, 1'b0, "d99_11");
        run_op(8'd100, 4'd7,  1'b0, "d100_7");
        run_op(8'd255, 4'd1,  1'b0, "d255_1");
        run_op(8'd0,   4'd15, 1'b0, "d0_15");
        run_op(8'd15,  4'd15, 1'b0, "d15_15");
        run_op(8'd5,   4'd0,  1'b0, "d5_0");

        // Mid-CALC START and operand churn must not disturb 200/3.
        run_op(8'd200, 4'd3, 1'b1, "d200_3_ignore");
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            ndone += int'(done);
        end
        chk("no_second_done", ndone, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 4'($urandom), bit'($urandom_range(0, 1)), "rand");
        end

        // START held high: back-to-back operations every 10 cycles.
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd9;
        ndone    = 0;
        bad_hold = 0;
        cyc      = 0;
        while (ndone < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (ndone > 0 && (quotient !== 8'd11 || remainder !== 4'd0)) bad_hold++;
            if (done) begin
                t_done[ndone] = cyc;
                ndone++;
                chk("held_quotient", quotient, 11);
                chk("held_remainder", remainder, 0);
            end
        end
        start = 1'b0;
        chk("held_done_count", ndone, 3);
        if (ndone == 3) begin
            chk("held_spacing_1", t_done[1] - t_done[0], 10);
            chk("held_spacing_2", t_done[2] - t_done[1], 10);
        end
        chk("held_outputs_stable", bad_hold, 0);
        repeat (3) @(posedge clk);
        #1;
        last_q = 8'd11;

        // Asynchronous reset in the middle of CALC.
        start    = 1'b1;
        dividend = 8'd120;
        divisor  = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("areset_quotient", quotient, 0);
        chk("areset_remainder", remainder, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_div_zero", div_zero, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            ndone += int'(done) + int'(busy);
        end
        chk("areset_idle_after", ndone, 0);
        last_q = 8'd0;
        run_op(8'd120, 4'd7, 1'b0, "d120_7_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
